// File: rtl/led_flicker_arb_pkg.sv
// Shared types and helpers for the LED flicker CSR arbiter.
// Optional build macro: LED_FLICKER_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package led_flicker_arb_pkg;

   localparam int MAX_MASTERS = 8;

   typedef logic [2:0] master_id_t;

   typedef struct packed {
      logic       valid;
      master_id_t id;
   } rd_tag_t;

   // Index of the master following idx, wrapping back to 0 after the last one.
   function automatic master_id_t next_idx(input master_id_t idx, input int cnt);
      if (int'(idx) >= (cnt - 1)) begin
         return 3'd0;
      end else begin
         return idx + 3'd1;
      end
   endfunction

endpackage

// File: rtl/led_flicker_rr_pick.sv
// Combinational rotating picker: grants the first requester found at or
// after the start pointer, wrapping modulo N. Output grant is one-hot.
module led_flicker_rr_pick
   import led_flicker_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  master_id_t   start,
   output logic [N-1:0] grant,
   output master_id_t   idx,
   output logic         any
);

   int   cand_s;
   logic hit_s;

   // Scan requesters starting at the pointer; the first hit wins.
   always_comb begin
      grant  = '0;
      idx    = 3'd0;
      any    = 1'b0;
      cand_s = 0;
      hit_s  = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand_s        = (int'(start) + k) % N;
         hit_s         = ~any & req[cand_s];
         grant[cand_s] = grant[cand_s] | hit_s;
         idx           = hit_s ? master_id_t'(cand_s) : idx;
         any           = any | hit_s;
      end
   end

endmodule

// File: rtl/led_flicker_csr_arbiter.sv
// Arbitrates several Avalon-MM masters onto the single LED flicker CSR slave port.
// Commands are forwarded with zero added latency; read tags follow the slave's
// fixed read latency so each readdatavalid returns to the master that issued it.
// Optional build macro: LED_FLICKER_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins, no rotating pointer); otherwise round-robin is used.
module led_flicker_csr_arbiter
   import led_flicker_arb_pkg::*;
#(
   parameter int MASTERS_CNT  = 2,
   parameter int ADDR_W       = 1,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [MASTERS_CNT-1:0][ADDR_W-1:0]    m_address_i,
   input  logic [MASTERS_CNT-1:0][DATA_W-1:0]    m_writedata_i,
   input  logic [MASTERS_CNT-1:0]                m_read_i,
   input  logic [MASTERS_CNT-1:0]                m_write_i,
   output logic [MASTERS_CNT-1:0][DATA_W-1:0]    m_readdata_o,
   output logic [MASTERS_CNT-1:0]                m_readdatavalid_o,
   output logic [MASTERS_CNT-1:0]                m_waitrequest_o,
   output logic [ADDR_W-1:0]                     s_address_o,
   output logic [DATA_W-1:0]                     s_writedata_o,
   output logic                                  s_read_o,
   output logic                                  s_write_o,
   input  logic [DATA_W-1:0]                     s_readdata_i,
   input  logic                                  s_readdatavalid_i,
   input  logic                                  s_waitrequest_i
);

   logic [MASTERS_CNT-1:0]              req_s;
   logic [MASTERS_CNT-1:0]              grant_s;
   master_id_t                          gnt_idx_s;
   master_id_t                          start_s;
   logic                                any_s;
   logic                                accept_s;
   logic                                rd_accept_s;
   logic                                ret_s;
   logic [MASTERS_CNT-1:0]              rdv_s;
   rd_tag_t                             tag_r [READ_LATENCY];
   logic [MASTERS_CNT-1:0][DATA_W-1:0]  rdata_r;

   // Requests are masked while reset is held so nothing reaches the slave.
   always_comb begin
      if (rst_i) begin
         req_s = '0;
      end else begin
         req_s = m_read_i | m_write_i;
      end
   end

`ifdef LED_FLICKER_ARB_FIXED_PRIO_EN
   assign start_s = 3'd0;
`else
   master_id_t rr_ptr_r;

   // Rotating pointer moves past the granted master only when its command is accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_r <= 3'd0;
      end else if (accept_s) begin
         rr_ptr_r <= next_idx(gnt_idx_s, MASTERS_CNT);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   assign start_s = rr_ptr_r;
`endif

   led_flicker_rr_pick #(
      .N (MASTERS_CNT)
   ) u_pick (
      .req   (req_s),
      .start (start_s),
      .grant (grant_s),
      .idx   (gnt_idx_s),
      .any   (any_s)
   );

   // Forward the granted command to the slave and stall every other master.
   always_comb begin
      s_address_o     = '0;
      s_writedata_o   = '0;
      s_read_o        = 1'b0;
      s_write_o       = 1'b0;
      m_waitrequest_o = '1;
      for (int i = 0; i < MASTERS_CNT; i++) begin
         if (grant_s[i]) begin
            s_address_o        = m_address_i[i];
            s_writedata_o      = m_writedata_i[i];
            s_write_o          = m_write_i[i];
            // A simultaneous read+write is treated as a write only.
            s_read_o           = m_read_i[i] & ~m_write_i[i];
            m_waitrequest_o[i] = s_waitrequest_i;
         end else begin
            m_waitrequest_o[i] = 1'b1;
         end
      end
   end

   assign accept_s    = any_s & ~s_waitrequest_i;
   assign rd_accept_s = accept_s & s_read_o;

   // Read tag shift register: one stage per cycle of slave read latency.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < READ_LATENCY; k++) begin
            tag_r[k] <= '0;
         end
      end else begin
         if (rd_accept_s) begin
            tag_r[0] <= rd_tag_t'{valid: 1'b1, id: gnt_idx_s};
         end else begin
            tag_r[0] <= '0;
         end
         for (int k = 1; k < READ_LATENCY; k++) begin
            tag_r[k] <= tag_r[k-1];
         end
      end
   end

   // Route returning slave data to the tagged master; untagged data is dropped.
   always_comb begin
      ret_s = s_readdatavalid_i & tag_r[READ_LATENCY-1].valid;
      rdv_s = '0;
      for (int i = 0; i < MASTERS_CNT; i++) begin
         rdv_s[i]        = ret_s & (tag_r[READ_LATENCY-1].id == master_id_t'(i));
         m_readdata_o[i] = rdv_s[i] ? s_readdata_i : rdata_r[i];
      end
      m_readdatavalid_o = rdv_s;
   end

   // Keep each master's last returned read data visible between returns.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_r <= '0;
      end else begin
         for (int i = 0; i < MASTERS_CNT; i++) begin
            if (rdv_s[i]) begin
               rdata_r[i] <= s_readdata_i;
            end else begin
               rdata_r[i] <= rdata_r[i];
            end
         end
      end
   end

endmodule

// File: doc/led_flicker_csr_arbiter.md
Name: led_flicker_csr_arbiter

Overview:
- Shares the single Avalon-MM CSR slave port of the LED flicker register file between MASTERS_CNT requesters, e.g. the HPS lightweight bridge and a local FPGA sequencer.
- Arbitrates read and write commands (round-robin by default) and forwards one command per cycle.
- Tracks outstanding reads through the slave's fixed read latency and returns each readdatavalid to the master that issued it.
- Sits between the interconnect masters and the regfile CSR port.

Parameters:
- MASTERS_CNT, 2: number of requesting masters, 2..8.
- ADDR_W, 1: CSR address width.
- DATA_W, 32: CSR data width, equal to the regfile REG_SIZE.
- READ_LATENCY, 1: fixed slave cycles from read accept to readdatavalid, 1..4.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- m_address_i  in  [MASTERS_CNT-1:0][ADDR_W-1:0]  per-master address.
- m_writedata_i  in  [MASTERS_CNT-1:0][DATA_W-1:0]  per-master write data.
- m_read_i  in  [MASTERS_CNT-1:0]  per-master read request.
- m_write_i  in  [MASTERS_CNT-1:0]  per-master write request.
- m_readdata_o  out  [MASTERS_CNT-1:0][DATA_W-1:0]  per-master read data.
- m_readdatavalid_o  out  [MASTERS_CNT-1:0]  per-master read data valid.
- m_waitrequest_o  out  [MASTERS_CNT-1:0]  per-master stall.
- s_address_o  out  ADDR_W  to regfile.
- s_writedata_o  out  DATA_W  to regfile.
- s_read_o  out  1  to regfile.
- s_write_o  out  1  to regfile.
- s_readdata_i  in  DATA_W  from regfile.
- s_readdatavalid_i  in  1  from regfile.
- s_waitrequest_i  in  1  from regfile.

Behaviour:
- Request definitions:
  - req[i] = m_read_i[i] | m_write_i[i].
  - If a master asserts read and write together, the command is a write; its read is not forwarded.
- Grant:
  - Combinational, one-hot.
  - Search starts at rr_ptr and wraps modulo MASTERS_CNT; the first requester found is granted.
  - No requesters: no grant, s_read_o = s_write_o = 0.
- Slave forwarding:
  - s_* carry the granted master's command in the same cycle (zero added latency).
  - s_address_o / s_writedata_o are 0 when there is no grant.
- Waitrequest:
  - Granted master: m_waitrequest_o = s_waitrequest_i.
  - Every other master: m_waitrequest_o = 1.
- Accept and pointer update:
  - accept = grant & ~s_waitrequest_i.
  - On accept, rr_ptr <= granted index + 1, wrapping at MASTERS_CNT-1 -> 0.
  - Otherwise rr_ptr holds, so a stalled grant stays with the same master.
- Read tag pipeline:
  - READ_LATENCY stages, each holding {valid, master id}.
  - An accepted read loads stage 0 with {1, id}; all stages shift every cycle.
- Read return:
  - When s_readdatavalid_i = 1 and the last stage is valid, m_readdatavalid_o[id] = 1 for one cycle and m_readdata_o[id] = s_readdata_i, both combinational.
  - All other m_readdata_o hold their last value.
- Stray data: s_readdatavalid_i with the last stage invalid is dropped and no master sees it.
- Missing data: last stage valid without s_readdatavalid_i means the read is lost and no master is signalled. Lost and stray reads are left to SVA assertions in the verification code only.
- Back-to-back:
  - Reads from different masters may be accepted on consecutive cycles; tags keep them ordered.
  - Full throughput is 1 command per cycle.
- Reset (asynchronous), any time including mid-read:
  - rr_ptr = 0, all tag stages invalid, all m_readdata_o = 0.
  - m_waitrequest_o all 1 while rst_i is high; m_readdatavalid_o all 0.
  - s_read_o = s_write_o = 0 while rst_i is high.
  - Slave data returning after reset for a pre-reset read is dropped as stray.

Optional Feature:
- Macro: LED_FLICKER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed and master 0 can starve the others.
- Undefined: round-robin as described above.

Decomposition:
- Package led_flicker_arb_pkg:
  - master_id_t: logic [2:0].
  - rd_tag_t: struct {valid, master_id_t id}.
  - Constant MAX_MASTERS = 8.
- Sub-module led_flicker_rr_pick: combinational round-robin picker; inputs req vector and start pointer; outputs one-hot grant and index.

Test Plan:
- Single write: master 1 writes 0x000003E8 to address 0 with s_waitrequest_i = 0 -> s_write_o = 1 in the same cycle, m_waitrequest_o = 2'b01, rr_ptr becomes 0.
- Simultaneous reads: both masters read with READ_LATENCY = 1 and rr_ptr = 0 -> master 0 accepted in cycle N, master 1 in N+1; slave returns 0x1F4 then 0x2A -> m_readdatavalid_o[0] in N+1 carries 0x1F4, m_readdatavalid_o[1] in N+2 carries 0x2A.
- Slave stall: s_waitrequest_i = 1 for 3 cycles while master 0 writes and master 1 also requests -> grant stays on master 0 for all 3 cycles, rr_ptr unchanged; accepted on cycle 4, master 1 granted on cycle 5.
- Reset mid-read: read accepted, rst_i pulsed before data returns -> no m_readdatavalid_o asserted; all m_waitrequest_o = 1 during reset.
- Read and write together: master 0 asserts both with data 0x10 -> only s_write_o asserted, no readdatavalid ever returned to master 0.
- LED_FLICKER_ARB_FIXED_PRIO_EN defined: both masters request continuously for 4 cycles -> master 0 accepted every cycle, m_waitrequest_o[1] = 1 throughout.
